// File: rtl/timed_decoder.sv
// timed_decoder: sequential 2-to-4 decoder with an input FIFO and timed output.
//
// Encoded codes {zero, Y} arrive over a valid/ready handshake and are queued
// in a small FIFO. Each queued code is shown on a registered one-hot bus W
// for HOLD_CYCLES cycles, followed by a single blank GAP cycle in which done
// pulses. A code with zero=1 is a blank slot: it takes the same time and also
// produces done, but W stays 0000.
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset
//   Y[1:0]   in   encoded index (00 -> W[0] ... 11 -> W[3])
//   zero     in   1 = no line active (Y ignored)
//   in_valid in   {zero,Y} valid this cycle
//   in_ready out  FIFO not full (decoded from the occupancy register)
//   W[3:0]   out  registered one-hot output or 0000
//   busy     out  registered, 1 while in HOLD or GAP
//   done     out  registered single-cycle pulse in the GAP cycle
module timed_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] Y,
  input  logic       zero,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] W,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       w_q;
  logic             busy_q;
  logic             done_q;

  // FIFO storage holds {zero, Y}; contents need no reset because the
  // pointers and occupancy define which entries are live.
  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             push;
  logic             pop;
  logic [2:0]       head;

  function automatic logic [3:0] decode(input logic [2:0] entry);
    decode = entry[2] ? 4'b0000 : (4'b0001 << entry[1:0]);
  endfunction

  // Ready depends only on the occupancy register, so a pop on the same edge
  // never lets a push into a full FIFO.
  assign in_ready = (occ_q != OCC_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (occ_q != '0) && ((state_q == IDLE) || (state_q == GAP));
  assign head     = mem_q[rd_ptr_q];

  assign W    = w_q;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {zero, Y};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (pop) begin
            w_q     <= decode(head);
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            w_q    <= 4'b0000;
            busy_q <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            w_q     <= 4'b0000;
            done_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          // GAP lasts exactly one cycle; a waiting code is loaded directly
          // so back-to-back codes run at HOLD_CYCLES+1 cycles each.
          done_q <= 1'b0;
          if (pop) begin
            w_q     <= decode(head);
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            w_q     <= 4'b0000;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          w_q     <= 4'b0000;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
